// File: rtl/ram_dp_param_pkg.sv
// Shared constants for the parametrised dual-port RAM family.
package ram_dp_param_pkg;

    // Collision behaviour selectors
    localparam int unsigned COLLIDE_READ_FIRST  = 0;
    localparam int unsigned COLLIDE_WRITE_FIRST = 1;
    localparam int unsigned COLLIDE_LEGACY      = 2;

    // Supported read latency range
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    // True when a parameter set can be built
    function automatic logic params_ok(
        input int unsigned data_w,
        input int unsigned byte_w,
        input int unsigned rd_lat,
        input int unsigned collide_mode
    );
        logic ok;
        ok = 1'b1;
        if (byte_w == 0 || data_w == 0)                   ok = 1'b0;
        else if ((data_w % byte_w) != 0)                  ok = 1'b0;
        if (rd_lat < RD_LAT_MIN || rd_lat > RD_LAT_MAX)   ok = 1'b0;
        if (collide_mode > COLLIDE_LEGACY)                ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Storage array with per-lane write and registered synchronous read.
// The array itself has no reset; only the read register is cleared.
module ram_dp_core
    import ram_dp_param_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned BYTE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [DATA_W/BYTE_W-1:0] be_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     re_i,
    input  logic [ADDR_W-1:0]        raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    localparam int unsigned NBE   = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Per-lane write; lanes with a cleared enable keep their contents
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NBE; i++) begin
            if (we_i && be_i[i]) begin
                mem_q[waddr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read register: samples the pre-write word on a same-address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_dp_param.sv
// Parametrised simple dual-port RAM: byte-enable writes, 1/2-cycle read
// latency, read_valid pulse and selectable read/write collision behaviour.
module ram_dp_param
    import ram_dp_param_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned BYTE_W       = 8,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned COLLIDE_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write_en,
    input  logic [DATA_W/BYTE_W-1:0] write_be,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     read_en,
    input  logic [ADDR_W-1:0]        read_addr,
    output logic [DATA_W-1:0]        read_data,
    output logic                     read_valid
);

    localparam int unsigned NBE = DATA_W / BYTE_W;

    localparam logic IS_LEGACY      = (COLLIDE_MODE == COLLIDE_LEGACY);
    localparam logic IS_WRITE_FIRST = (COLLIDE_MODE == COLLIDE_WRITE_FIRST);

    // Refuse to build an unsupported configuration
    if (!params_ok(DATA_W, BYTE_W, RD_LAT, COLLIDE_MODE)) begin : g_bad_params
        $error("ram_dp_param: illegal DATA_W/BYTE_W/RD_LAT/COLLIDE_MODE combination");
    end

    logic              accept_c;
    logic              hit_c;
    logic [DATA_W-1:0] core_rdata;
    logic [DATA_W-1:0] merged_c;

    logic [NBE-1:0]    coll_be_q;
    logic [DATA_W-1:0] coll_data_q;
    logic              v1_q;

    // Legacy mode drops a read whenever a write is presented
    assign accept_c = read_en && !(IS_LEGACY && write_en);

    // Same-address write alongside an accepted read, only honoured in write-first mode
    assign hit_c = IS_WRITE_FIRST && accept_c && write_en && (read_addr == write_addr);

    ram_dp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYTE_W (BYTE_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (write_en),
        .be_i    (write_be),
        .waddr_i (write_addr),
        .wdata_i (write_data),
        .re_i    (accept_c),
        .raddr_i (read_addr),
        .rdata_o (core_rdata)
    );

    // Collision merge register: remembers which lanes must come from the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_be_q   <= '0;
            coll_data_q <= '0;
        end else if (accept_c) begin
            coll_be_q   <= hit_c ? write_be : '0;
            coll_data_q <= write_data;
        end
    end

    // First valid stage, aligned with the core read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= accept_c;
        end
    end

    // Lane-wise merge of stored word and colliding write data
    always_comb begin
        merged_c = core_rdata;
        for (int unsigned i = 0; i < NBE; i++) begin
            if (coll_be_q[i]) begin
                merged_c[i*BYTE_W +: BYTE_W] = coll_data_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] out_q;
        logic              v2_q;

        // Output register stage; later writes cannot disturb a captured result
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
                v2_q  <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    out_q <= merged_c;
                end
            end
        end

        assign read_data  = out_q;
        assign read_valid = v2_q;
    end else begin : g_lat1
        assign read_data  = merged_c;
        assign read_valid = v1_q;
    end

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: four configurations share one stimulus stream and
// are checked every cycle against a word-level reference model.
module tb_ram_dp_param;

    localparam int NI = 4;
    localparam int unsigned LAT  [NI] = '{1, 2, 2, 1};
    localparam int unsigned MODE [NI] = '{0, 1, 2, 2};

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_be;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd [NI];
    logic        rv [NI];

    int checks = 0;
    int errors = 0;

    ram_dp_param #(.RD_LAT(1), .COLLIDE_MODE(0)) d0 (
        .clk(clk), .rst_n(rst_n), .write_en(wr_en), .write_be(wr_be),
        .write_addr(wr_addr), .write_data(wr_data), .read_en(rd_en),
        .read_addr(rd_addr), .read_data(rd[0]), .read_valid(rv[0]));
    ram_dp_param #(.RD_LAT(2), .COLLIDE_MODE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .write_en(wr_en), .write_be(wr_be),
        .write_addr(wr_addr), .write_data(wr_data), .read_en(rd_en),
        .read_addr(rd_addr), .read_data(rd[1]), .read_valid(rv[1]));
    ram_dp_param #(.RD_LAT(2), .COLLIDE_MODE(2)) d2 (
        .clk(clk), .rst_n(rst_n), .write_en(wr_en), .write_be(wr_be),
        .write_addr(wr_addr), .write_data(wr_data), .read_en(rd_en),
        .read_addr(rd_addr), .read_data(rd[2]), .read_valid(rv[2]));
    ram_dp_param #(.RD_LAT(1), .COLLIDE_MODE(2)) d3 (
        .clk(clk), .rst_n(rst_n), .write_en(wr_en), .write_be(wr_be),
        .write_addr(wr_addr), .write_data(wr_data), .read_en(rd_en),
        .read_addr(rd_addr), .read_data(rd[3]), .read_valid(rv[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] mmem [NI][16];
    logic        ev   [NI];
    logic [15:0] ed   [NI];
    logic        pv   [NI];
    logic [15:0] pd   [NI];
    logic        m_acc;
    logic [15:0] m_cur;
    int          vcnt [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            ev[i] = 1'b0; ed[i] = '0; pv[i] = 1'b0; pd[i] = '0; vcnt[i] = 0;
        end
    end

    // Model: what each configuration must present after this edge
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            m_acc = rd_en && !(MODE[i] == 2 && wr_en);
            m_cur = mmem[i][rd_addr];
            if (MODE[i] == 1 && wr_en && rd_addr == wr_addr) begin
                for (int b = 0; b < 2; b++)
                    if (wr_be[b]) m_cur[b*8 +: 8] = wr_data[b*8 +: 8];
            end
            if (!rst_n) begin
                ev[i] = 1'b0; ed[i] = '0; pv[i] = 1'b0; pd[i] = '0;
            end else if (LAT[i] == 1) begin
                ev[i] = m_acc;
                if (m_acc) ed[i] = m_cur;
            end else begin
                ev[i] = pv[i];
                if (pv[i]) ed[i] = pd[i];
                pv[i] = m_acc;
                if (m_acc) pd[i] = m_cur;
            end
            if (wr_en) begin
                for (int b = 0; b < 2; b++)
                    if (wr_be[b]) mmem[i][wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    // Every-cycle comparison of all instances against the model
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            if (rv[i] === 1'b1) vcnt[i]++;
            checks++;
            if (rv[i] !== ev[i]) begin
                errors++;
                $display("FAIL model_valid inst%0d got %b exp %b at %0t", i, rv[i], ev[i], $time);
            end
            checks++;
            if (rd[i] !== ed[i]) begin
                errors++;
                $display("FAIL model_data inst%0d got %h exp %h at %0t", i, rd[i], ed[i], $time);
            end
        end
    end

    task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] be, input logic [3:0] wa,
                         input logic [15:0] wd, input logic re, input logic [3:0] ra);
        @(negedge clk);
        wr_en = we; wr_be = be; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0);
    endtask

    int base [NI];

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;

        // Reset and idle quiet period
        repeat (3) idle();
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            idle();
            lit("reset_valid_l1", 16'(rv[0]), 16'h0);
            lit("reset_data_l2",  rd[1],      16'h0);
        end

        // Basic write then read
        drive(1'b1, 2'b11, 4'd3, 16'hA5A5, 1'b0, 4'd0);
        drive(1'b0, 2'b00, 4'd0, 16'h0,    1'b1, 4'd3);
        idle();
        lit("wr_rd_l1_data",  rd[0],      16'hA5A5);
        lit("wr_rd_l1_valid", 16'(rv[0]), 16'h1);
        lit("wr_rd_l2_early", 16'(rv[1]), 16'h0);
        idle();
        lit("wr_rd_l2_data",  rd[1],      16'hA5A5);
        lit("wr_rd_l2_valid", 16'(rv[1]), 16'h1);
        lit("wr_rd_l1_pulse", 16'(rv[0]), 16'h0);

        // Byte enables
        drive(1'b1, 2'b11, 4'd5, 16'h1234, 1'b0, 4'd0);
        drive(1'b1, 2'b01, 4'd5, 16'hABCD, 1'b0, 4'd0);
        drive(1'b0, 2'b00, 4'd0, 16'h0,    1'b1, 4'd5);
        idle();
        lit("be01_l1", rd[0], 16'h12CD);
        drive(1'b1, 2'b00, 4'd5, 16'hABCD, 1'b0, 4'd0);
        drive(1'b0, 2'b00, 4'd0, 16'h0,    1'b1, 4'd5);
        idle();
        idle();
        lit("be00_l2",       rd[1],      16'h12CD);
        lit("be00_l2_valid", 16'(rv[1]), 16'h1);

        // Same-address collision
        drive(1'b1, 2'b11, 4'd7, 16'h1111, 1'b0, 4'd0);
        drive(1'b1, 2'b10, 4'd7, 16'h2222, 1'b1, 4'd7);
        idle();
        lit("coll_m0_data",       rd[0],      16'h1111);
        lit("coll_m0_valid",      16'(rv[0]), 16'h1);
        lit("coll_m2_l1_valid",   16'(rv[3]), 16'h0);
        lit("coll_m2_l1_hold",    rd[3],      16'h12CD);
        idle();
        lit("coll_m1_data",       rd[1],      16'h2211);
        lit("coll_m1_valid",      16'(rv[1]), 16'h1);
        lit("coll_m2_l2_valid",   16'(rv[2]), 16'h0);
        lit("coll_m2_l2_hold",    rd[2],      16'h12CD);

        // Fill and stream every address back-to-back
        for (int a = 0; a < 16; a++)
            drive(1'b1, 2'b11, 4'(a), 16'(a * 16'h0101), 1'b0, 4'd0);
        for (int i = 0; i < NI; i++) base[i] = vcnt[i];
        for (int a = 0; a < 16; a++)
            drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'(a));
        idle();
        lit("stream_last_l1", rd[0], 16'h0F0F);
        idle();
        idle();
        for (int i = 0; i < NI; i++)
            lit($sformatf("stream_count_inst%0d", i), 16'(vcnt[i] - base[i]), 16'd16);

        // Reset while a latency-2 read is in flight
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd9);
        @(negedge clk);
        rd_en = 1'b0;
        rst_n = 1'b0;
        #1;
        lit("rst_mid_l2_data",  rd[1],      16'h0);
        lit("rst_mid_l2_valid", 16'(rv[1]), 16'h0);
        idle();
        idle();
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle();
            lit("post_rst_l2_valid", 16'(rv[1]), 16'h0);
            lit("post_rst_l2_data",  rd[1],      16'h0);
        end
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd9);
        idle();
        lit("retain_l1", rd[0], 16'h0909);
        idle();
        lit("retain_l2", rd[1], 16'h0909);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
